// File: rtl/mem_stage_vlat.sv
// Memory pipeline stage: holds one instruction until its data-SRAM response arrives, then formats load data for WB.
// Latency 0 when data_ok coincides with the stage; backpressure from ws_allowin parks the response in a buffer.
module mem_stage_vlat #(
  parameter int DATA_W = 32,
  localparam int AW = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ws_allowin,
  output logic              ms_allowin,
  input  logic              es_to_ms_valid,
  input  logic              es_mem_req,
  input  logic              es_is_load,
  input  logic [1:0]        es_ld_size,
  input  logic              es_ld_unsigned,
  input  logic [AW-1:0]     es_addr_low,
  input  logic              es_gr_we,
  input  logic [4:0]        es_dest,
  input  logic [DATA_W-1:0] es_result,
  input  logic [31:0]       es_pc,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  input  logic              flush,
  output logic              ms_to_ws_valid,
  output logic              ms_gr_we,
  output logic [4:0]        ms_dest,
  output logic [DATA_W-1:0] ms_final_result,
  output logic [31:0]       ms_pc,
  output logic              ms_fwd_valid,
  output logic              ms_fwd_blk,
  output logic [4:0]        ms_fwd_dest,
  output logic [DATA_W-1:0] ms_fwd_data
);

  typedef struct packed {
    logic              mem_req;
    logic              is_load;
    logic [1:0]        ld_size;
    logic              ld_unsigned;
    logic [AW-1:0]     addr_low;
    logic              gr_we;
    logic [4:0]        dest;
    logic [DATA_W-1:0] result;
    logic [31:0]       pc;
  } ms_fields_t;

  ms_fields_t        ms_r;
  ms_fields_t        es_fields;
  logic              ms_valid;
  logic              got_r;
  logic [DATA_W-1:0] buf_r;
  logic [1:0]        discard_cnt;
  logic [1:0]        cnt_next;

  logic              disc_idle;
  logic              resp_ok;
  logic              ready_go;
  logic              handoff;
  logic              accept;
  logic              capture;
  logic              kill_pending;
  logic              kill_incoming;
  logic              drop;

  logic [DATA_W-1:0] resp_src;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ld_mask;
  logic              ld_sign;
  logic [DATA_W-1:0] ld_data;

  assign es_fields = '{
    mem_req:     es_mem_req,
    is_load:     es_is_load,
    ld_size:     es_ld_size,
    ld_unsigned: es_ld_unsigned,
    addr_low:    es_addr_low,
    gr_we:       es_gr_we,
    dest:        es_dest,
    result:      es_result,
    pc:          es_pc
  };

  // Responses owed to killed instructions are swallowed before any new one may be attributed.
  assign disc_idle = (discard_cnt == 2'd0);
  assign resp_ok   = data_sram_data_ok && disc_idle;
  assign drop      = data_sram_data_ok && !disc_idle;

  assign ready_go       = !ms_r.mem_req || got_r || resp_ok;
  assign ms_allowin     = disc_idle && (!ms_valid || (ready_go && ws_allowin));
  assign ms_to_ws_valid = ms_valid && ready_go && !flush;
  assign handoff        = ms_to_ws_valid && ws_allowin;
  assign accept         = es_to_ms_valid && ms_allowin && !flush;
  assign capture        = resp_ok && ms_valid && ms_r.mem_req && !got_r && !handoff && !flush;

  assign kill_pending  = flush && ms_valid && ms_r.mem_req && !got_r && !resp_ok;
  assign kill_incoming = flush && es_to_ms_valid && es_mem_req;
  assign cnt_next      = discard_cnt + {1'b0, kill_pending} + {1'b0, kill_incoming} - {1'b0, drop};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid    <= 1'b0;
      ms_r        <= '0;
      got_r       <= 1'b0;
      buf_r       <= '0;
      discard_cnt <= 2'd0;
    end else begin
      if (flush || ms_allowin) begin
        ms_valid <= accept;
      end
      if (accept) begin
        ms_r <= es_fields;
      end
      if (flush || accept) begin
        got_r <= 1'b0;
      end else if (capture) begin
        got_r <= 1'b1;
      end
      if (capture) begin
        buf_r <= data_sram_rdata;
      end
      discard_cnt <= cnt_next;
    end
  end

  assign resp_src = got_r ? buf_r : data_sram_rdata;
  assign shifted  = resp_src >> {ms_r.addr_low, 3'b000};

  always_comb begin
    ld_mask = '1;
    ld_sign = shifted[DATA_W-1];
    case (ms_r.ld_size)
      2'd0: begin
        ld_mask = DATA_W'(8'hFF);
        ld_sign = shifted[7];
      end
      2'd1: begin
        ld_mask = DATA_W'(16'hFFFF);
        ld_sign = shifted[15];
      end
      2'd2: begin
        ld_mask = DATA_W'(32'hFFFF_FFFF);
        ld_sign = shifted[31];
      end
      default: begin
        ld_mask = '1;
        ld_sign = shifted[DATA_W-1];
      end
    endcase
    ld_data = (shifted & ld_mask) | ({DATA_W{ld_sign && !ms_r.ld_unsigned}} & ~ld_mask);
  end

  assign ms_final_result = ms_r.is_load ? ld_data : ms_r.result;
  assign ms_gr_we        = ms_valid && ms_r.gr_we;
  assign ms_dest         = ms_r.dest;
  assign ms_pc           = ms_r.pc;

  assign ms_fwd_valid = ms_valid && ms_r.gr_we;
  assign ms_fwd_blk   = ms_valid && ms_r.is_load && !got_r && !resp_ok;
  assign ms_fwd_dest  = ms_r.dest;
  assign ms_fwd_data  = ms_final_result;

endmodule

// File: tb/tb_mem_stage_vlat.sv
// Directed bench for mem_stage_vlat: a 32-bit and a 64-bit instance driven in lockstep.
module tb_mem_stage_vlat;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_allowin;
  logic        es_to_ms_valid;
  logic        es_mem_req;
  logic        es_is_load;
  logic [1:0]  es_ld_size;
  logic        es_ld_unsigned;
  logic [2:0]  es_addr_low;
  logic        es_gr_we;
  logic [4:0]  es_dest;
  logic [63:0] es_result;
  logic [31:0] es_pc;
  logic        data_ok;
  logic [63:0] rdata;
  logic        flush;

  logic        a_allowin, a_to_ws, a_gr_we, a_fwd_valid, a_fwd_blk;
  logic [4:0]  a_dest, a_fwd_dest;
  logic [31:0] a_final, a_pc, a_fwd_data;
  logic        b_allowin, b_to_ws, b_gr_we, b_fwd_valid, b_fwd_blk;
  logic [4:0]  b_dest, b_fwd_dest;
  logic [63:0] b_final, b_fwd_data;
  logic [31:0] b_pc;

  always #5 clk = ~clk;

  mem_stage_vlat #(.DATA_W(32)) dut32 (
    .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin), .ms_allowin(a_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_mem_req(es_mem_req), .es_is_load(es_is_load),
    .es_ld_size(es_ld_size), .es_ld_unsigned(es_ld_unsigned), .es_addr_low(es_addr_low[1:0]),
    .es_gr_we(es_gr_we), .es_dest(es_dest), .es_result(es_result[31:0]), .es_pc(es_pc),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata[31:0]), .flush(flush),
    .ms_to_ws_valid(a_to_ws), .ms_gr_we(a_gr_we), .ms_dest(a_dest), .ms_final_result(a_final),
    .ms_pc(a_pc), .ms_fwd_valid(a_fwd_valid), .ms_fwd_blk(a_fwd_blk), .ms_fwd_dest(a_fwd_dest),
    .ms_fwd_data(a_fwd_data)
  );

  mem_stage_vlat #(.DATA_W(64)) dut64 (
    .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin), .ms_allowin(b_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_mem_req(es_mem_req), .es_is_load(es_is_load),
    .es_ld_size(es_ld_size), .es_ld_unsigned(es_ld_unsigned), .es_addr_low(es_addr_low),
    .es_gr_we(es_gr_we), .es_dest(es_dest), .es_result(es_result), .es_pc(es_pc),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata), .flush(flush),
    .ms_to_ws_valid(b_to_ws), .ms_gr_we(b_gr_we), .ms_dest(b_dest), .ms_final_result(b_final),
    .ms_pc(b_pc), .ms_fwd_valid(b_fwd_valid), .ms_fwd_blk(b_fwd_blk), .ms_fwd_dest(b_fwd_dest),
    .ms_fwd_data(b_fwd_data)
  );

  typedef struct {
    bit          w64;
    bit          is_load;
    bit          mem_req;
    logic [1:0]  size;
    bit          uns;
    logic [2:0]  addr;
    logic [63:0] result;
    logic [63:0] rd;
    logic [63:0] exp;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    es_to_ms_valid = 1'b0;
    es_mem_req     = 1'b0;
    es_is_load     = 1'b0;
    es_ld_size     = 2'd0;
    es_ld_unsigned = 1'b0;
    es_addr_low    = 3'd0;
    es_gr_we       = 1'b0;
    es_dest        = 5'd0;
    es_result      = 64'd0;
    es_pc          = 32'd0;
    data_ok        = 1'b0;
    rdata          = 64'd0;
    flush          = 1'b0;
  endtask

  task automatic offer_load(input logic [1:0] sz, input bit uns, input logic [2:0] a, input logic [4:0] d);
    es_to_ms_valid = 1'b1;
    es_mem_req     = 1'b1;
    es_is_load     = 1'b1;
    es_ld_size     = sz;
    es_ld_unsigned = uns;
    es_addr_low    = a;
    es_gr_we       = 1'b1;
    es_dest        = d;
    es_result      = 64'd0;
    es_pc          = 32'h2000 + 32'(d);
  endtask

  function automatic vec_t mk(bit w, bit ld, bit mr, logic [1:0] sz, bit u, logic [2:0] a,
                              logic [63:0] res, logic [63:0] rd, logic [63:0] ex);
    vec_t v;
    v.w64 = w; v.is_load = ld; v.mem_req = mr; v.size = sz; v.uns = u; v.addr = a;
    v.result = res; v.rd = rd; v.exp = ex;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] fin;
    logic        vld;
    logic        blk;
    logic [4:0]  dst;

    vecs[0]  = mk(0, 1, 1, 2'd0, 0, 3'd3, 64'd0, 64'h8012_3456, 64'hFFFF_FF80);
    vecs[1]  = mk(0, 1, 1, 2'd0, 1, 3'd3, 64'd0, 64'h8012_3456, 64'h0000_0080);
    vecs[2]  = mk(0, 1, 1, 2'd0, 0, 3'd0, 64'd0, 64'h0000_007F, 64'h0000_007F);
    vecs[3]  = mk(0, 1, 1, 2'd1, 0, 3'd0, 64'd0, 64'h1234_8001, 64'hFFFF_8001);
    vecs[4]  = mk(0, 1, 1, 2'd1, 1, 3'd2, 64'd0, 64'hBEEF_0000, 64'h0000_BEEF);
    vecs[5]  = mk(0, 1, 1, 2'd1, 0, 3'd2, 64'd0, 64'hBEEF_0000, 64'hFFFF_BEEF);
    vecs[6]  = mk(0, 1, 1, 2'd2, 0, 3'd0, 64'd0, 64'hDEAD_BEEF, 64'hDEAD_BEEF);
    vecs[7]  = mk(0, 1, 1, 2'd0, 0, 3'd1, 64'd0, 64'h0000_A500, 64'hFFFF_FFA5);
    vecs[8]  = mk(0, 0, 0, 2'd0, 0, 3'd0, 64'hCAFE_F00D, 64'h1111_1111, 64'hCAFE_F00D);
    vecs[9]  = mk(1, 1, 1, 2'd2, 0, 3'd4, 64'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000);
    vecs[10] = mk(1, 1, 1, 2'd2, 1, 3'd4, 64'd0, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000);
    vecs[11] = mk(1, 1, 1, 2'd3, 0, 3'd0, 64'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    vecs[12] = mk(1, 1, 1, 2'd0, 0, 3'd7, 64'd0, 64'h8100_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF81);
    vecs[13] = mk(1, 1, 1, 2'd1, 0, 3'd6, 64'd0, 64'h7FFF_0000_0000_0000, 64'h0000_0000_0000_7FFF);

    resetn = 1'b0;
    ws_allowin = 1'b1;
    idle_inputs();
    #2;
    chk("reset allowin",   64'(a_allowin),   64'd1);
    chk("reset to_ws",     64'(a_to_ws),     64'd0);
    chk("reset fwd_valid", 64'(a_fwd_valid), 64'd0);
    chk("reset fwd_blk",   64'(a_fwd_blk),   64'd0);
    chk("reset result",    64'(a_final),     64'd0);
    chk("reset64 allowin", 64'(b_allowin),   64'd1);
    tick();
    tick();
    resetn = 1'b1;

    // Table: latch one instruction, deliver its response in the next cycle with WB ready.
    for (int i = 0; i < NV; i++) begin
      tick();
      es_to_ms_valid = 1'b1;
      es_mem_req     = vecs[i].mem_req;
      es_is_load     = vecs[i].is_load;
      es_ld_size     = vecs[i].size;
      es_ld_unsigned = vecs[i].uns;
      es_addr_low    = vecs[i].addr;
      es_gr_we       = 1'b1;
      es_dest        = 5'(i + 1);
      es_result      = vecs[i].result;
      es_pc          = 32'h1000 + 32'(i * 4);
      tick();
      es_to_ms_valid = 1'b0;
      data_ok        = vecs[i].mem_req;
      rdata          = vecs[i].rd;
      #2;
      if (vecs[i].w64) begin
        fin = b_final; vld = b_to_ws; blk = b_fwd_blk; dst = b_dest;
      end else begin
        fin = 64'(a_final); vld = a_to_ws; blk = a_fwd_blk; dst = a_dest;
      end
      chk($sformatf("vec%0d result", i), fin, vecs[i].exp);
      chk($sformatf("vec%0d to_ws", i), 64'(vld), 64'd1);
      chk($sformatf("vec%0d fwd_blk", i), 64'(blk), 64'd0);
      chk($sformatf("vec%0d dest", i), 64'(dst), 64'(i + 1));
      tick();
      data_ok = 1'b0;
    end

    // ld.hu, response three cycles late; a stray data_ok while empty must be ignored.
    tick();
    offer_load(2'd1, 1'b1, 3'd2, 5'd7);
    data_ok = 1'b1;
    rdata   = 64'h0;
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      #2;
      chk($sformatf("late blk c%0d", k), 64'(a_fwd_blk), 64'd1);
      chk($sformatf("late to_ws c%0d", k), 64'(a_to_ws), 64'd0);
      tick();
    end
    data_ok = 1'b1;
    rdata   = 64'hBEEF_0000;
    #2;
    chk("late blk done", 64'(a_fwd_blk), 64'd0);
    chk("late to_ws",    64'(a_to_ws),   64'd1);
    chk("late result",   64'(a_final),   64'h0000_BEEF);
    tick();
    data_ok = 1'b0;

    // Response while WB stalls four cycles: held from the buffer.
    tick();
    offer_load(2'd2, 1'b0, 3'd0, 5'd8);
    tick();
    idle_inputs();
    ws_allowin = 1'b0;
    data_ok    = 1'b1;
    rdata      = 64'h1234_5678;
    #2;
    chk("stall to_ws c0",   64'(a_to_ws),   64'd1);
    chk("stall allowin c0", 64'(a_allowin), 64'd0);
    chk("stall result c0",  64'(a_final),   64'h1234_5678);
    for (int k = 1; k < 4; k++) begin
      tick();
      data_ok = 1'b0;
      rdata   = 64'hFFFF_FFFF_FFFF_FFFF;
      #2;
      chk($sformatf("stall result c%0d", k), 64'(a_final), 64'h1234_5678);
      chk($sformatf("stall to_ws c%0d", k),  64'(a_to_ws), 64'd1);
    end
    tick();
    ws_allowin = 1'b1;
    #2;
    chk("stall release to_ws",   64'(a_to_ws),   64'd1);
    chk("stall release allowin", 64'(a_allowin), 64'd1);
    chk("stall release result",  64'(a_final),   64'h1234_5678);
    tick();
    #2;
    chk("stall handed off", 64'(a_to_ws), 64'd0);

    // Flush with a pending load in the stage and another load entering.
    tick();
    offer_load(2'd2, 1'b0, 3'd0, 5'd9);
    tick();
    offer_load(2'd2, 1'b0, 3'd0, 5'd10);
    flush = 1'b1;
    #2;
    chk("flush to_ws",   64'(a_to_ws),   64'd0);
    chk("flush allowin", 64'(a_allowin), 64'd0);
    tick();
    flush = 1'b0;
    offer_load(2'd2, 1'b0, 3'd0, 5'd11);
    data_ok = 1'b1;
    rdata   = 64'h1111_1111;
    #2;
    chk("discard1 allowin",   64'(a_allowin),   64'd0);
    chk("discard1 to_ws",     64'(a_to_ws),     64'd0);
    chk("discard1 fwd_valid", 64'(a_fwd_valid), 64'd0);
    tick();
    rdata = 64'h2222_2222;
    #2;
    chk("discard2 allowin", 64'(a_allowin), 64'd0);
    chk("discard2 to_ws",   64'(a_to_ws),   64'd0);
    tick();
    data_ok = 1'b0;
    #2;
    chk("discard done allowin", 64'(a_allowin), 64'd1);
    tick();
    es_to_ms_valid = 1'b0;
    data_ok = 1'b1;
    rdata   = 64'h3333_3333;
    #2;
    chk("after flush to_ws",  64'(a_to_ws), 64'd1);
    chk("after flush result", 64'(a_final), 64'h3333_3333);
    chk("after flush dest",   64'(a_dest),  64'd11);
    tick();
    data_ok = 1'b0;

    // Reset while a load waits, then a store completes without a register write.
    tick();
    offer_load(2'd0, 1'b0, 3'd1, 5'd12);
    tick();
    idle_inputs();
    #2;
    chk("pre-reset blk", 64'(a_fwd_blk), 64'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk("mid-reset to_ws",     64'(a_to_ws),     64'd0);
    chk("mid-reset fwd_valid", 64'(a_fwd_valid), 64'd0);
    chk("mid-reset fwd_blk",   64'(a_fwd_blk),   64'd0);
    chk("mid-reset allowin",   64'(a_allowin),   64'd1);
    chk("mid-reset result",    64'(a_final),     64'd0);
    chk("mid-reset pc",        64'(a_pc),        64'd0);
    chk("mid-reset dest",      64'(a_dest),      64'd0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    es_to_ms_valid = 1'b1;
    es_mem_req     = 1'b1;
    es_is_load     = 1'b0;
    es_gr_we       = 1'b0;
    es_dest        = 5'd13;
    es_result      = 64'h5555_AAAA;
    tick();
    idle_inputs();
    #2;
    chk("store wait to_ws", 64'(a_to_ws),   64'd0);
    chk("store wait blk",   64'(a_fwd_blk), 64'd0);
    tick();
    data_ok = 1'b1;
    rdata   = 64'hFFFF_FFFF;
    #2;
    chk("store to_ws",  64'(a_to_ws), 64'd1);
    chk("store gr_we",  64'(a_gr_we), 64'd0);
    chk("store result", 64'(a_final), 64'h5555_AAAA);
    tick();
    data_ok = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
